// File: rtl/cpu_mem_access_ctrl.sv
// CPU memory access controller: SRAM with fixed wait states,
// register bus with ack/timeout, one response per request, NES open bus.
// Ports: clk, rst (async, active-high); req_* request in; rsp_* response out;
//   sram_* external SRAM strobes/addr/data; reg_* register bus strobes/addr/data/ack.
module cpu_mem_access_ctrl #(
  parameter int          SRAM_WAIT   = 2,
  parameter int          REG_TIMEOUT = 15,
  parameter logic [15:0] XROM_BASE   = 16'h0800,
  parameter logic [15:0] WRAM_BASE   = 16'h27E0,
  parameter logic [15:0] PRG_BASE    = 16'h47E0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] dec_addr,
  input  logic        dec_valid,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_wdata,
  input  logic [7:0]  sram_rdata,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd,
  output logic        reg_wr,
  input  logic        reg_ack,
  input  logic [7:0]  reg_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    SRAM,
    REG,
    RESP
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] tcnt;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic [7:0]  open_bus;

  logic        prot;
  logic [7:0]  sram_d;
  logic [7:0]  reg_d;
  logic [7:0]  tmo_d;

  // Expansion ROM and PRG-ROM windows reject writes
  assign prot = req_we &&
                (((dec_addr >= XROM_BASE) && (dec_addr < WRAM_BASE)) ||
                 (dec_addr >= PRG_BASE));

  // Writes report their own data back; reads report the bus
  assign sram_d = we_q ? wdata_q : sram_rdata;
  assign reg_d  = we_q ? wdata_q : reg_rdata;
  assign tmo_d  = we_q ? wdata_q : open_bus;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      open_bus   <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_we    <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_rd     <= 1'b0;
      reg_wr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (dec_valid && prot) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= req_wdata;
            end else if (dec_valid) begin
              state      <= SRAM;
              cnt        <= 16'(SRAM_WAIT);
              sram_ce    <= 1'b1;
              sram_oe    <= ~req_we;
              sram_we    <= req_we;
              sram_addr  <= dec_addr;
              sram_wdata <= req_we ? req_wdata : 8'h00;
            end else begin
              state     <= REG;
              tcnt      <= 16'd1;
              reg_rd    <= ~req_we;
              reg_wr    <= req_we;
              reg_addr  <= dec_addr;
              reg_wdata <= req_we ? req_wdata : 8'h00;
            end
          end
        end
        SRAM: begin
          if (cnt == '0) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_rdata  <= sram_d;
            open_bus   <= sram_d;
            sram_ce    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        REG: begin
          // Ack on the timeout cycle still counts as success
          if (reg_ack || (tcnt == 16'(REG_TIMEOUT))) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ~reg_ack;
            rsp_rdata <= reg_ack ? reg_d : tmo_d;
            if (reg_ack) begin
              open_bus <= reg_d;
            end
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          cnt       <= '0;
          tcnt      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_access_ctrl.sv
// Bench for cpu_mem_access_ctrl: transaction-level model of the expected
// timeline per request, a per-cycle compare process and literal pins.
module tb_cpu_mem_access_ctrl;

  localparam int SW = 2;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] dec_addr = '0;
  logic        dec_valid = 1'b0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = '0;
  logic        sram_ce, sram_oe, sram_we;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_rd, reg_wr;
  logic        reg_ack = 1'b0;
  logic [7:0]  reg_rdata = '0;

  cpu_mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .dec_addr(dec_addr), .dec_valid(dec_valid), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the request in flight
  bit          m_busy = 1'b0;
  int          m_acc = 0;
  int          m_win = 0;
  bit          m_sram, m_we, m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic [7:0]  ob = 8'h00;

  bit          seen;
  int          seen_k;
  logic [7:0]  seen_d;
  logic        seen_e;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int k;
    bit win, rsp, idl;
    if (!rst) begin
      k = m_busy ? cyc - m_acc : 0;
      win = m_busy && k >= 1 && k <= m_win;
      rsp = m_busy && k == m_win + 1;
      idl = !(win || rsp);
      chk("req_ready", 16'(req_ready), 16'(idl));
      chk("sram_ce", 16'(sram_ce), 16'(win && m_sram));
      chk("sram_oe", 16'(sram_oe), 16'(win && m_sram && !m_we));
      chk("sram_we", 16'(sram_we), 16'(win && m_sram && m_we));
      chk("reg_rd", 16'(reg_rd), 16'(win && !m_sram && !m_we));
      chk("reg_wr", 16'(reg_wr), 16'(win && !m_sram && m_we));
      if (win && m_sram) chk("sram_addr", sram_addr, m_addr);
      if (win && m_sram && m_we) chk("sram_wdata", 16'(sram_wdata), 16'(m_wdata));
      if (win && !m_sram) chk("reg_addr", reg_addr, m_addr);
      if (win && !m_sram && m_we) chk("reg_wdata", 16'(reg_wdata), 16'(m_wdata));
      if (idl) begin
        chk("sram_addr_idle", sram_addr, 16'h0);
        chk("reg_addr_idle", reg_addr, 16'h0);
        chk("sram_wdata_idle", 16'(sram_wdata), 16'h0);
        chk("reg_wdata_idle", 16'(reg_wdata), 16'h0);
      end
      chk("rsp_valid", 16'(rsp_valid), 16'(rsp));
      chk("rsp_err", 16'(rsp_err), 16'(rsp && m_err));
      if (rsp) chk("rsp_rdata", 16'(rsp_rdata), 16'(m_rdata));
      if (rsp_valid) begin
        seen   = 1'b1;
        seen_k = k;
        seen_d = rsp_rdata;
        seen_e = rsp_err;
      end
    end
  end

  task automatic setup(input bit we, input bit dv, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] rd,
                       input int ack_at);
    bit prot;
    prot = dv && we && ((a >= 16'h0800 && a < 16'h27E0) || a >= 16'h47E0);
    m_we = we; m_addr = a; m_wdata = wd; m_sram = dv && !prot;
    if (prot) begin
      m_win = 0; m_err = 1'b1; m_rdata = wd;
    end else if (dv) begin
      m_win = SW + 1; m_err = 1'b0; m_rdata = we ? wd : rd; ob = m_rdata;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      m_win = ack_at; m_err = 1'b0; m_rdata = we ? wd : rd; ob = m_rdata;
    end else begin
      m_win = TO; m_err = 1'b1; m_rdata = we ? wd : ob;
    end
    sram_rdata = rd; reg_rdata = rd;
    req_we = we; dec_valid = dv; dec_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    seen = 1'b0;
    m_acc = cyc;
    m_busy = 1'b1;
  endtask

  task automatic run(input bit we, input bit dv, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] rd,
                     input int ack_at);
    @(negedge clk);
    setup(we, dv, a, wd, rd, ack_at);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= m_win + 2; k++) begin
      @(negedge clk);
      reg_ack = !dv && (k == ack_at);
    end
    reg_ack = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic pin(input string nm, input int k, input logic [7:0] d,
                     input bit e);
    chk({nm, "_seen"}, 16'(seen), 16'h1);
    chk({nm, "_cycle"}, 16'(seen_k), 16'(k));
    chk({nm, "_rdata"}, 16'(seen_d), 16'(d));
    chk({nm, "_err"}, 16'(seen_e), 16'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Requests during reset are ignored
    req_valid = 1'b1; dec_valid = 1'b1; dec_addr = 16'h0123;
    repeat (3) @(negedge clk);
    chk("rst_ready", 16'(req_ready), 16'h1);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_sram_ce", 16'(sram_ce), 16'h0);
    chk("rst_reg_rd", 16'(reg_rd), 16'h0);
    chk("rst_sram_addr", sram_addr, 16'h0);
    req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;

    run(0, 1, 16'h0123, 8'h00, 8'h5A, 0);  pin("t1_sram_rd", 4, 8'h5A, 0);
    run(1, 1, 16'h27E0, 8'h3C, 8'h00, 0);  pin("t2_wram_wr", 4, 8'h3C, 0);
    run(1, 1, 16'h0800, 8'h11, 8'h00, 0);  pin("t3_xrom_wr", 1, 8'h11, 1);
    run(1, 1, 16'h47E0, 8'h22, 8'h00, 0);  pin("t3_prg_wr", 1, 8'h22, 1);
    run(1, 1, 16'h27DF, 8'h33, 8'h00, 0);  pin("xrom_top_wr", 1, 8'h33, 1);
    run(1, 1, 16'h47DF, 8'h44, 8'h00, 0);  pin("wram_top_wr", 4, 8'h44, 0);
    run(0, 1, 16'h0800, 8'h00, 8'hA5, 0);  pin("xrom_rd", 4, 8'hA5, 0);
    run(0, 0, 16'h2002, 8'h00, 8'h80, 3);  pin("t4_reg_rd", 4, 8'h80, 0);
    run(0, 0, 16'h4016, 8'h00, 8'hEE, 0);  pin("t5_reg_tmo", 16, 8'h80, 1);
    run(1, 0, 16'h4014, 8'h77, 8'h00, 1);  pin("reg_wr_ack1", 2, 8'h77, 0);
    run(0, 0, 16'h4017, 8'h00, 8'h11, 0);  pin("tmo_ob_wr", 16, 8'h77, 1);
    run(0, 0, 16'h2007, 8'h00, 8'h99, 15); pin("ack_at_tmo", 16, 8'h99, 0);
    run(1, 0, 16'h2006, 8'h55, 8'h00, 0);  pin("reg_wr_tmo", 16, 8'h55, 1);
    run(0, 0, 16'h4017, 8'h00, 8'h00, 0);  pin("tmo_ob_keep", 16, 8'h99, 1);

    // Reset in cycle 2 of an SRAM write
    @(negedge clk);
    setup(1, 1, 16'h3000, 8'h5E, 8'h00, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("t6_ce_before", 16'(sram_ce), 16'h1);
    #1 rst = 1'b1;
    m_busy = 1'b0;
    ob = 8'h00;
    #1;
    chk("t6_ce_drop", 16'(sram_ce), 16'h0);
    chk("t6_we_drop", 16'(sram_we), 16'h0);
    chk("t6_addr_drop", sram_addr, 16'h0);
    chk("t6_ready", 16'(req_ready), 16'h1);
    chk("t6_rsp", 16'(rsp_valid), 16'h0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_rsp", 16'(seen), 16'h0);

    run(0, 0, 16'h4016, 8'h00, 8'h00, 0);  pin("t6_ob_reset", 16, 8'h00, 1);
    run(1, 1, 16'h3000, 8'h5E, 8'h00, 0);  pin("t6_next", 4, 8'h5E, 0);
    run(0, 1, 16'h0123, 8'h00, 8'hC3, 0);  pin("t6_next_rd", 4, 8'hC3, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
